// File: rtl/bias_buffer_writeback_ctrl.sv
// Drains the banked bias buffer back to DDR, bank-major, through a 2-entry output queue.
// One DDR write burst is configured per job; the queue is never overrun by read issue.
module bias_buffer_writeback_ctrl #(
    parameter int X_PE         = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int SINGLE_LEN   = 24,
    parameter int BUFFER_NUM   = 8 * X_PE / DATA_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           conf,
    input  logic [SINGLE_LEN-1:0]          wb_num,
    input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
    input  logic [ADDR_LEN-1:0]            bb_st_addr,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    output logic [ADDR_LEN-1:0]            bb_addr,
    output logic [BUFFER_NUM-1:0]          bb_rd_en,
    input  logic [BUFFER_NUM*DATA_LEN-1:0] bb_rdata,
    input  logic                           ddr_fifo_full,
    output logic                           ddr_fifo_wr,
    output logic [DATA_LEN-1:0]            ddr_fifo_data,
    output logic                           idle,
    output logic                           done
);

    localparam int BANK_W = (BUFFER_NUM > 1) ? $clog2(BUFFER_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                  r_state;
    logic [SINGLE_LEN-1:0]   r_wb_num;
    logic [SINGLE_LEN-1:0]   r_k;
    logic [ADDR_LEN-1:0]     r_bb_st;
    logic [ADDR_LEN-1:0]     r_addr;
    logic [BANK_W-1:0]       r_bank;
    logic [DDR_ADDR_LEN-1:0] r_ddr_addr;
    logic [SINGLE_LEN-1:0]   r_ddr_len;
    logic                    r_ddr_conf;
    logic                    r_idle;
    logic                    r_done;

    logic                    r_vld_p1;
    logic [BANK_W-1:0]       r_bank_p1;

    logic [DATA_LEN-1:0]     r_q0;
    logic [DATA_LEN-1:0]     r_q1;
    logic [1:0]              r_cnt;

    logic                    w_accept;
    logic [2:0]              w_load;
    logic                    w_issue;
    logic                    w_last_k;
    logic                    w_last_bank;
    logic                    w_empty_next;
    logic [DATA_LEN-1:0]     w_rdata;

    // Committed occupancy after this cycle: a new read is allowed only if its word will fit.
    assign w_accept     = (r_cnt != 2'd0) && !ddr_fifo_full;
    assign w_load       = 3'(r_cnt) + 3'(r_vld_p1) - 3'(w_accept);
    assign w_issue      = (r_state == S_RUN) && (w_load < 3'd2);
    assign w_last_k     = (r_k == r_wb_num - SINGLE_LEN'(1));
    assign w_last_bank  = (r_bank == BANK_W'(BUFFER_NUM - 1));
    assign w_empty_next = !r_vld_p1 && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_accept));
    assign w_rdata      = bb_rdata[int'(r_bank_p1)*DATA_LEN +: DATA_LEN];

    assign bb_rd_en        = w_issue ? (BUFFER_NUM'(1) << r_bank) : '0;
    assign bb_addr         = r_addr;
    assign ddr_fifo_wr     = w_accept;
    assign ddr_fifo_data   = r_q0;
    assign ddr_st_addr_out = r_ddr_addr;
    assign ddr_len         = r_ddr_len;
    assign ddr_conf        = r_ddr_conf;
    assign idle            = r_idle;
    assign done            = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wb_num   <= '0;
            r_k        <= '0;
            r_bb_st    <= '0;
            r_addr     <= '0;
            r_bank     <= '0;
            r_ddr_addr <= '0;
            r_ddr_len  <= '0;
            r_ddr_conf <= 1'b0;
            r_idle     <= 1'b1;
            r_done     <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_bank_p1  <= '0;
        end else begin
            r_ddr_conf <= 1'b0;
            r_done     <= 1'b0;
            // p1: read in flight, bank index follows to pick the returning slice
            r_vld_p1   <= w_issue;
            if (w_issue) r_bank_p1 <= r_bank;
            case (r_state)
                S_IDLE: begin
                    if (conf) begin
                        if (wb_num != '0) begin
                            r_wb_num   <= wb_num;
                            r_bb_st    <= bb_st_addr;
                            r_addr     <= bb_st_addr;
                            r_k        <= '0;
                            r_bank     <= '0;
                            r_ddr_addr <= ddr_st_addr;
                            r_ddr_len  <= SINGLE_LEN'(wb_num * SINGLE_LEN'(X_PE));
                            r_ddr_conf <= 1'b1;
                            r_idle     <= 1'b0;
                            r_state    <= S_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (w_last_k) begin
                            r_k    <= '0;
                            r_addr <= r_bb_st;
                            if (w_last_bank) r_state <= S_FLUSH;
                            else             r_bank  <= r_bank + BANK_W'(1);
                        end else begin
                            r_k    <= r_k + SINGLE_LEN'(1);
                            r_addr <= r_addr + ADDR_LEN'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_empty_next) begin
                        r_done  <= 1'b1;
                        r_idle  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // p2: output queue, r_q0 is the head presented to the DDR FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            if (r_vld_p1 && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_accept)))
                r_q0 <= w_rdata;
            else if (w_accept)
                r_q0 <= r_q1;
            if (r_vld_p1 && (((r_cnt == 2'd1) && !w_accept) || (r_cnt == 2'd2)))
                r_q1 <= w_rdata;
            r_cnt <= r_cnt + 2'(r_vld_p1) - 2'(w_accept);
        end
    end

endmodule

// File: tb/tb_bias_buffer_writeback_ctrl.sv
// Scoreboard bench for bias_buffer_writeback_ctrl: bank memory model, full-pattern driver,
// expected read/write streams queued per job and popped as the DUT produces them.
module tb_bias_buffer_writeback_ctrl;

    localparam int X_PE         = 16;
    localparam int DDR_ADDR_LEN = 32;
    localparam int ADDR_LEN     = 16;
    localparam int DATA_LEN     = 64;
    localparam int SINGLE_LEN   = 24;
    localparam int BUFFER_NUM   = 2;

    logic                           clk;
    logic                           rst;
    logic                           conf;
    logic [SINGLE_LEN-1:0]          wb_num;
    logic [DDR_ADDR_LEN-1:0]        ddr_st_addr;
    logic [ADDR_LEN-1:0]            bb_st_addr;
    logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]          ddr_len;
    logic                           ddr_conf;
    logic [ADDR_LEN-1:0]            bb_addr;
    logic [BUFFER_NUM-1:0]          bb_rd_en;
    logic [BUFFER_NUM*DATA_LEN-1:0] bb_rdata;
    logic                           ddr_fifo_full;
    logic                           ddr_fifo_wr;
    logic [DATA_LEN-1:0]            ddr_fifo_data;
    logic                           idle;
    logic                           done;

    bias_buffer_writeback_ctrl #(
        .X_PE(X_PE), .DDR_ADDR_LEN(DDR_ADDR_LEN), .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(DATA_LEN), .SINGLE_LEN(SINGLE_LEN), .BUFFER_NUM(BUFFER_NUM)
    ) dut (
        .clk(clk), .rst(rst), .conf(conf), .wb_num(wb_num),
        .ddr_st_addr(ddr_st_addr), .bb_st_addr(bb_st_addr),
        .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
        .bb_addr(bb_addr), .bb_rd_en(bb_rd_en), .bb_rdata(bb_rdata),
        .ddr_fifo_full(ddr_fifo_full), .ddr_fifo_wr(ddr_fifo_wr),
        .ddr_fifo_data(ddr_fifo_data), .idle(idle), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input int b, input logic [15:0] a);
        return {8'hB0 + 8'(b), 8'h5A, a, ~a, 16'h1357 ^ {8'(b), 8'(b)}};
    endfunction

    logic [63:0] exp_data[$];
    logic [31:0] exp_rd[$];

    int cyc = 0, rd_cnt = 0, wr_cnt = 0, conf_cnt = 0, done_cnt = 0;
    int first_rd = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
    int full_mode = 0, full_hold = 0;

    // Bank model: data appears for exactly the cycle after bb_rd_en, junk otherwise.
    initial begin
        logic [BUFFER_NUM-1:0] pend_en;
        logic [15:0]           pend_addr;
        logic [63:0]           ed;
        logic [31:0]           er;
        int                    b;
        bb_rdata      = '0;
        ddr_fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            pend_en   = bb_rd_en;
            pend_addr = bb_addr;
            if (bb_rd_en != '0) begin
                b = 0;
                for (int i = 0; i < BUFFER_NUM; i++) if (bb_rd_en[i]) b = i;
                chk("rd_onehot", 64'($onehot(bb_rd_en)), 64'd1);
                er = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hDEAD_BEEF;
                chk("rd_bank_addr", {16'(b), bb_addr}, er);
                if (rd_cnt == 0) first_rd = cyc;
                rd_cnt++;
            end
            if (ddr_fifo_wr) begin
                chk("wr_while_full", ddr_fifo_full, 0);
                ed = (exp_data.size() > 0) ? exp_data.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                chk("wr_data", ddr_fifo_data, ed);
                if (wr_cnt == 0) first_wr = cyc;
                wr_cnt++;
                last_wr = cyc;
            end
            if (ddr_conf) conf_cnt++;
            if (done) begin
                chk("idle_with_done", idle, 1);
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < BUFFER_NUM; i++)
                bb_rdata[i*DATA_LEN +: DATA_LEN] = pend_en[i] ? mem_word(i, pend_addr)
                                                              : {$urandom, $urandom};
            if (full_hold > 0) begin
                ddr_fifo_full = 1'b1;
                full_hold--;
            end else if (full_mode == 1) begin
                ddr_fifo_full = 1'($urandom_range(0, 1));
            end else begin
                ddr_fifo_full = 1'b0;
            end
        end
    end

    task automatic push_expect(input int wb, input logic [15:0] bb);
        for (int b = 0; b < BUFFER_NUM; b++)
            for (int k = 0; k < wb; k++) begin
                exp_rd.push_back({16'(b), 16'(bb + 16'(k))});
                exp_data.push_back(mem_word(b, 16'(bb + 16'(k))));
            end
    endtask

    task automatic run_job(input string nm, input int wb, input logic [15:0] bb,
                           input logic [31:0] da, input int fmode, input int fhold);
        int start_done;
        push_expect(wb, bb);
        rd_cnt = 0; wr_cnt = 0; conf_cnt = 0;
        start_done = done_cnt;
        full_mode  = fmode;
        full_hold  = fhold;
        @(posedge clk); #1;
        conf = 1'b1; wb_num = SINGLE_LEN'(wb); bb_st_addr = bb; ddr_st_addr = da;
        @(posedge clk); #1;
        conf = 1'b0;
        chk({nm, "_ddr_conf"}, ddr_conf, 1);
        chk({nm, "_ddr_len"}, ddr_len, SINGLE_LEN'(wb * X_PE));
        chk({nm, "_ddr_addr"}, ddr_st_addr_out, da);
        chk({nm, "_idle_low"}, idle, 0);
        if (fhold > 0) begin
            repeat (15) @(posedge clk);
            chk({nm, "_reads_le2_while_full"}, 64'(rd_cnt <= 2), 1);
            chk({nm, "_no_wr_while_full"}, wr_cnt, 0);
        end
        for (int i = 0; i < 2000 && done_cnt == start_done; i++) @(posedge clk);
        chk({nm, "_done_once"}, done_cnt - start_done, 1);
        chk({nm, "_wr_count"}, wr_cnt, BUFFER_NUM * wb);
        chk({nm, "_rd_count"}, rd_cnt, BUFFER_NUM * wb);
        chk({nm, "_conf_count"}, conf_cnt, 1);
        chk({nm, "_done_after_last_wr"}, done_cyc - last_wr, 1);
        chk({nm, "_sb_data_empty"}, exp_data.size(), 0);
        chk({nm, "_sb_rd_empty"}, exp_rd.size(), 0);
        if (fmode == 0 && fhold == 0) begin
            chk({nm, "_first_wr_latency"}, first_wr - first_rd, 2);
            chk({nm, "_back_to_back"}, last_wr - first_wr, BUFFER_NUM * wb - 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_idle_after"}, idle, 1);
        chk({nm, "_no_extra_done"}, done_cnt - start_done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int start_done;
        rst = 1'b1; conf = 1'b0; wb_num = '0; ddr_st_addr = '0; bb_st_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_done", done, 0);
        chk("rst_ddr_conf", ddr_conf, 0);
        chk("rst_rd_en", bb_rd_en, 0);
        chk("rst_fifo_wr", ddr_fifo_wr, 0);
        chk("rst_ddr_len", ddr_len, 0);
        chk("rst_ddr_addr", ddr_st_addr_out, 0);
        chk("rst_bb_addr", bb_addr, 0);
        chk("rst_fifo_data", ddr_fifo_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_job("t1", 4, 16'h0010, 32'h0000_1000, 0, 0);
        run_job("t2", 4, 16'h0010, 32'h0000_1000, 1, 0);
        run_job("t2b", 7, 16'h0123, 32'h0000_2040, 1, 0);
        run_job("t3", 4, 16'h0010, 32'h0000_1000, 0, 20);
        run_job("t4", 3, 16'hFFFE, 32'h0000_3000, 0, 0);

        rd_cnt = 0; conf_cnt = 0;
        start_done = done_cnt;
        @(posedge clk); #1;
        conf = 1'b1; wb_num = '0; bb_st_addr = 16'h0040; ddr_st_addr = 32'h0000_4000;
        @(posedge clk); #1;
        conf = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_idle", idle, 1);
        chk("t5_no_ddr_conf", ddr_conf, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_reads", rd_cnt, 0);
        chk("t5_conf_count", conf_cnt, 0);
        chk("t5_done_once", done_cnt - start_done, 1);

        push_expect(8, 16'h0200);
        @(posedge clk); #1;
        conf = 1'b1; wb_num = SINGLE_LEN'(8); bb_st_addr = 16'h0200; ddr_st_addr = 32'h0000_5000;
        @(posedge clk); #1;
        conf = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_rd_en", bb_rd_en, 0);
        chk("t6_rst_fifo_wr", ddr_fifo_wr, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_ddr_conf", ddr_conf, 0);
        exp_rd.delete();
        exp_data.delete();
        start_done = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("t6_no_stale_done", done_cnt - start_done, 0);
        run_job("t6b", 4, 16'h0300, 32'h0000_6000, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
